// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session sequencer - PIN authentication with retry lockout, menu
// dispatch, idle timeout and ledger req/ack. Macro ATM_DAILY_LIMIT_EN adds a per-session withdrawal cap.
module atm_session_ctrl #(
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int AMT_W       = 16
`ifdef ATM_DAILY_LIMIT_EN
    ,
    parameter int DAILY_LIMIT = 5000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic [11:0]      acc_num,
    input  logic [3:0]       pin,
    input  logic             pin_valid,
    input  logic             cmd_valid,
    input  logic [2:0]       menu_option,
    input  logic [AMT_W-1:0] amount,
    input  logic             exit,
    output logic             led_req,
    output logic [1:0]       led_op,
    output logic [11:0]      led_acc,
    output logic [3:0]       led_pin,
    output logic [AMT_W-1:0] led_amount,
    input  logic             led_ack,
    input  logic             led_ok,
    input  logic [AMT_W-1:0] led_balance,
    output logic [AMT_W-1:0] balance,
    output logic             valid,
    output logic             error,
    output logic             locked,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_AUTH     = 3'b001,
        ST_MENU     = 3'b010,
        ST_BALANCE  = 3'b011,
        ST_WITHDRAW = 3'b100,
        ST_DEPOSIT  = 3'b101,
        ST_LOCKED   = 3'b110
    } state_e;

    localparam logic [1:0] OP_VERIFY = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_DEBIT  = 2'b10;
    localparam logic [1:0] OP_CREDIT = 2'b11;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_e             state_r;
    logic [2:0]         tries_r;
    logic [CNT_W-1:0]   idle_cnt_r;
    logic               led_req_r;
    logic [1:0]         led_op_r;
    logic [11:0]        led_acc_r;
    logic [3:0]         led_pin_r;
    logic [AMT_W-1:0]   led_amount_r;
    logic [AMT_W-1:0]   balance_r;
    logic               valid_r;
    logic               error_r;
    logic               locked_r;
    logic               exit_pend_r;
    logic               leave_s;
    logic               timeout_s;
    logic               limit_hit_s;

    // Logout request and idle-expiry decode
    always_comb begin
        leave_s   = exit | ~card_in;
        timeout_s = (idle_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    end

`ifdef ATM_DAILY_LIMIT_EN
    logic [AMT_W:0]   total_r;
    logic [AMT_W+1:0] total_next_s;

    // Prospective session total if this withdrawal were forwarded
    always_comb begin
        total_next_s = {1'b0, total_r} + {2'b00, amount};
        limit_hit_s  = (total_next_s > (AMT_W+2)'(DAILY_LIMIT));
    end
`else
    assign limit_hit_s = 1'b0;
`endif

    // Session FSM with all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            tries_r      <= 3'd0;
            idle_cnt_r   <= '0;
            led_req_r    <= 1'b0;
            led_op_r     <= OP_VERIFY;
            led_acc_r    <= 12'd0;
            led_pin_r    <= 4'd0;
            led_amount_r <= '0;
            balance_r    <= '0;
            valid_r      <= 1'b0;
            error_r      <= 1'b0;
            locked_r     <= 1'b0;
            exit_pend_r  <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
            total_r      <= '0;
`endif
        end else begin
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idle_cnt_r  <= '0;
                    tries_r     <= 3'd0;
                    valid_r     <= 1'b0;
                    balance_r   <= '0;
                    exit_pend_r <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
                    total_r     <= '0;
`endif
                    if (card_in) begin
                        state_r <= ST_AUTH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_AUTH: begin
                    // An in-flight VERIFY always completes before logout is honoured
                    if (led_req_r) begin
                        if (led_ack) begin
                            led_req_r  <= 1'b0;
                            led_pin_r  <= 4'd0;
                            idle_cnt_r <= '0;
                            if (led_ok) begin
                                state_r <= ST_MENU;
                                valid_r <= 1'b1;
                                tries_r <= 3'd0;
                            end else begin
                                error_r <= 1'b1;
                                tries_r <= tries_r + 3'd1;
                                if (tries_r == 3'(MAX_TRIES - 1)) begin
                                    state_r  <= ST_LOCKED;
                                    locked_r <= 1'b1;
                                end else begin
                                    state_r <= ST_AUTH;
                                end
                            end
                        end else begin
                            state_r <= ST_AUTH;
                        end
                    end else if (leave_s || timeout_s) begin
                        state_r   <= ST_IDLE;
                        valid_r   <= 1'b0;
                        balance_r <= '0;
                        tries_r   <= 3'd0;
                        error_r   <= ~leave_s;
                    end else if (pin_valid) begin
                        led_acc_r  <= acc_num;
                        led_pin_r  <= pin;
                        led_op_r   <= OP_VERIFY;
                        led_req_r  <= 1'b1;
                        idle_cnt_r <= '0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_W'(1);
                    end
                end
                ST_MENU: begin
                    if (leave_s) begin
                        state_r   <= ST_IDLE;
                        valid_r   <= 1'b0;
                        balance_r <= '0;
                        tries_r   <= 3'd0;
                    end else if (cmd_valid) begin
                        idle_cnt_r <= '0;
                        case (menu_option)
                            3'b011: begin
                                state_r      <= ST_BALANCE;
                                led_op_r     <= OP_READ;
                                led_amount_r <= '0;
                                led_req_r    <= 1'b1;
                            end
                            3'b100: begin
                                if (amount == '0 || limit_hit_s) begin
                                    error_r <= 1'b1;
                                end else begin
                                    state_r      <= ST_WITHDRAW;
                                    led_op_r     <= OP_DEBIT;
                                    led_amount_r <= amount;
                                    led_req_r    <= 1'b1;
                                end
                            end
                            3'b101: begin
                                if (amount == '0) begin
                                    error_r <= 1'b1;
                                end else begin
                                    state_r      <= ST_DEPOSIT;
                                    led_op_r     <= OP_CREDIT;
                                    led_amount_r <= amount;
                                    led_req_r    <= 1'b1;
                                end
                            end
                            default: begin
                                error_r <= 1'b1;
                            end
                        endcase
                    end else if (timeout_s) begin
                        state_r   <= ST_IDLE;
                        valid_r   <= 1'b0;
                        balance_r <= '0;
                        tries_r   <= 3'd0;
                        error_r   <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_W'(1);
                    end
                end
                ST_BALANCE, ST_WITHDRAW, ST_DEPOSIT: begin
                    if (led_ack) begin
                        led_req_r    <= 1'b0;
                        led_amount_r <= '0;
                        idle_cnt_r   <= '0;
                        exit_pend_r  <= 1'b0;
                        error_r      <= ~led_ok;
`ifdef ATM_DAILY_LIMIT_EN
                        if (led_ok && state_r == ST_WITHDRAW) begin
                            total_r <= total_r + {1'b0, led_amount_r};
                        end else begin
                            total_r <= total_r;
                        end
`endif
                        // Logout seen at any point during the op takes effect now
                        if (exit_pend_r || leave_s) begin
                            state_r   <= ST_IDLE;
                            valid_r   <= 1'b0;
                            balance_r <= '0;
                            tries_r   <= 3'd0;
                        end else begin
                            state_r <= ST_MENU;
                            if (led_ok) begin
                                balance_r <= led_balance;
                            end else begin
                                balance_r <= balance_r;
                            end
                        end
                    end else if (leave_s) begin
                        exit_pend_r <= 1'b1;
                    end else begin
                        exit_pend_r <= exit_pend_r;
                    end
                end
                ST_LOCKED: begin
                    if (!card_in) begin
                        state_r  <= ST_IDLE;
                        locked_r <= 1'b0;
                        tries_r  <= 3'd0;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    led_req_r <= 1'b0;
                    valid_r   <= 1'b0;
                    locked_r  <= 1'b0;
                end
            endcase
        end
    end

    assign led_req    = led_req_r;
    assign led_op     = led_op_r;
    assign led_acc    = led_acc_r;
    assign led_pin    = led_pin_r;
    assign led_amount = led_amount_r;
    assign balance    = balance_r;
    assign valid      = valid_r;
    assign error      = error_r;
    assign locked     = locked_r;
    assign state      = state_r;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: scenario tasks drive the session controller; a ledger model pops
// expected requests from a scoreboard queue and answers them.
module tb_atm_session_ctrl;

    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        card_in = 1'b0;
    logic [11:0] acc_num = 12'd0;
    logic [3:0]  pin = 4'd0;
    logic        pin_valid = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  menu_option = 3'd0;
    logic [15:0] amount = 16'd0;
    logic        exit = 1'b0;
    logic        led_req;
    logic [1:0]  led_op;
    logic [11:0] led_acc;
    logic [3:0]  led_pin;
    logic [15:0] led_amount;
    logic        led_ack = 1'b0;
    logic        led_ok = 1'b0;
    logic [15:0] led_balance = 16'd0;
    logic [15:0] balance;
    logic        valid;
    logic        error;
    logic        locked;
    logic [2:0]  state;

    typedef struct packed {
        logic [1:0]  op;
        logic [11:0] acc;
        logic [3:0]  pin;
        logic [15:0] amt;
    } req_t;

    req_t sb_q[$];
    int total = 0;
    int bad = 0;

    atm_session_ctrl #(.MAX_TRIES(3), .TIMEOUT_CYC(TIMEOUT), .AMT_W(16)) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .acc_num(acc_num), .pin(pin),
        .pin_valid(pin_valid), .cmd_valid(cmd_valid), .menu_option(menu_option),
        .amount(amount), .exit(exit), .led_req(led_req), .led_op(led_op),
        .led_acc(led_acc), .led_pin(led_pin), .led_amount(led_amount),
        .led_ack(led_ack), .led_ok(led_ok), .led_balance(led_balance),
        .balance(balance), .valid(valid), .error(error), .locked(locked), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_pin(input logic [11:0] a, input logic [3:0] p);
        acc_num = a; pin = p; pin_valid = 1'b1;
        step();
        pin_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] opt, input logic [15:0] amt);
        menu_option = opt; amount = amt; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Ledger model: wait for a request, check it against the scoreboard, ack after delay
    task automatic ledger_serve(input int delay, input logic ok, input logic [15:0] bal);
        req_t exp_r;
        int waited;
        waited = 0;
        while (led_req !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (sb_q.size() > 0) exp_r = sb_q.pop_front();
        else exp_r = '1;
        total++;
        if (led_req !== 1'b1) begin
            bad++;
            $display("FAIL led_req_seen: led_req=%b want 1", led_req);
            return;
        end
        total++;
        if ({led_op, led_acc, led_pin, led_amount} !== exp_r) begin
            bad++;
            $display("FAIL led_fields: op=%0d acc=%0h pin=%0h amt=%0d want op=%0d acc=%0h pin=%0h amt=%0d",
                     led_op, led_acc, led_pin, led_amount, exp_r.op, exp_r.acc, exp_r.pin, exp_r.amt);
        end
        for (int i = 0; i < delay; i++) begin
            step();
            total++;
            if (led_req !== 1'b1 || led_op !== exp_r.op || led_amount !== exp_r.amt) begin
                bad++;
                $display("FAIL req_hold: req=%b op=%0d amt=%0d want 1 %0d %0d", led_req, led_op, led_amount, exp_r.op, exp_r.amt);
            end
        end
        led_ack = 1'b1; led_ok = ok; led_balance = bal;
        step();
        led_ack = 1'b0; led_ok = 1'b0; led_balance = 16'd0;
        total++;
        if (led_req !== 1'b0) begin
            bad++;
            $display("FAIL req_drop: led_req=%b want 0", led_req);
        end
    endtask

    task automatic login(input logic [11:0] a, input logic [3:0] p);
        card_in = 1'b1;
        step();
        sb_q.push_back({2'b00, a, p, 16'd0});
        strobe_pin(a, p);
        ledger_serve(0, 1'b1, 16'd0);
        total++;
        if (state !== 3'd2 || valid !== 1'b1) begin
            bad++;
            $display("FAIL login: state=%0d valid=%b want 2 1", state, valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        total++;
        if (state !== 3'd0 || valid !== 1'b0 || error !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: state=%0d valid=%b error=%b locked=%b want 0 0 0 0", state, valid, error, locked);
        end
        total++;
        if (led_req !== 1'b0 || led_op !== 2'd0 || led_acc !== 12'd0 || led_pin !== 4'd0 ||
            led_amount !== 16'd0 || balance !== 16'd0) begin
            bad++;
            $display("FAIL reset_ledger: req=%b op=%0d acc=%0h pin=%0h amt=%0d bal=%0d want all 0",
                     led_req, led_op, led_acc, led_pin, led_amount, balance);
        end
    endtask

    task automatic test_lockout();
        int errs;
        errs = 0;
        card_in = 1'b1;
        step();
        total++;
        if (state !== 3'd1) begin bad++; $display("FAIL auth_entry: state=%0d want 1", state); end
        for (int k = 1; k <= 3; k++) begin
            sb_q.push_back({2'b00, 12'h5a3, 4'h7, 16'd0});
            strobe_pin(12'h5a3, 4'h7);
            ledger_serve(0, 1'b0, 16'd0);
            if (error === 1'b1) errs++;
            total++;
            if (state !== ((k == 3) ? 3'd6 : 3'd1) || locked !== (k == 3)) begin
                bad++;
                $display("FAIL lock_try%0d: state=%0d locked=%b", k, state, locked);
            end
        end
        total++;
        if (errs != 3) begin bad++; $display("FAIL lock_errors: got %0d want 3", errs); end
        strobe_pin(12'h5a3, 4'h7);
        total++;
        if (led_req !== 1'b0 || state !== 3'd6) begin
            bad++;
            $display("FAIL locked_ignore: led_req=%b state=%0d want 0 6", led_req, state);
        end
        card_in = 1'b0;
        step();
        total++;
        if (state !== 3'd0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL unlock: state=%0d locked=%b want 0 0", state, locked);
        end
    endtask

    task automatic test_balance();
        login(12'h321, 4'h2);
        sb_q.push_back({2'b01, 12'h321, 4'h0, 16'd0});
        send_cmd(3'b011, 16'd0);
        ledger_serve(0, 1'b1, 16'd1000);
        total++;
        if (balance !== 16'd1000 || error !== 1'b0 || valid !== 1'b1 || state !== 3'd2) begin
            bad++;
            $display("FAIL balance: bal=%0d err=%b valid=%b state=%0d want 1000 0 1 2", balance, error, valid, state);
        end
    endtask

    task automatic test_withdraw();
        sb_q.push_back({2'b10, 12'h321, 4'h0, 16'd100});
        send_cmd(3'b100, 16'd100);
        ledger_serve(0, 1'b1, 16'd900);
        total++;
        if (balance !== 16'd900 || error !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_ok: bal=%0d err=%b want 900 0", balance, error);
        end
        sb_q.push_back({2'b10, 12'h321, 4'h0, 16'd43000});
        send_cmd(3'b100, 16'd43000);
        ledger_serve(0, 1'b0, 16'd12345);
        total++;
        if (balance !== 16'd900 || error !== 1'b1 || state !== 3'd2) begin
            bad++;
            $display("FAIL withdraw_nsf: bal=%0d err=%b state=%0d want 900 1 2", balance, error, state);
        end
        send_cmd(3'b100, 16'd0);
        total++;
        if (error !== 1'b1 || led_req !== 1'b0 || state !== 3'd2) begin
            bad++;
            $display("FAIL zero_amount: err=%b req=%b state=%0d want 1 0 2", error, led_req, state);
        end
        send_cmd(3'b111, 16'd5);
        total++;
        if (error !== 1'b1 || led_req !== 1'b0 || state !== 3'd2) begin
            bad++;
            $display("FAIL bad_code: err=%b req=%b state=%0d want 1 0 2", error, led_req, state);
        end
        led_ack = 1'b1; led_ok = 1'b1; led_balance = 16'd7777;
        step();
        led_ack = 1'b0; led_ok = 1'b0; led_balance = 16'd0;
        total++;
        if (balance !== 16'd900 || state !== 3'd2 || error !== 1'b0) begin
            bad++;
            $display("FAIL stray_ack: bal=%0d state=%0d err=%b want 900 2 0", balance, state, error);
        end
    endtask

    task automatic test_deposit_delayed();
        sb_q.push_back({2'b11, 12'h321, 4'h0, 16'd2000});
        send_cmd(3'b101, 16'd2000);
        ledger_serve(5, 1'b1, 16'd2900);
        total++;
        if (balance !== 16'd2900 || error !== 1'b0 || state !== 3'd2) begin
            bad++;
            $display("FAIL deposit: bal=%0d err=%b state=%0d want 2900 0 2", balance, error, state);
        end
    endtask

    task automatic test_exit_with_cmd();
        exit = 1'b1;
        send_cmd(3'b011, 16'd0);
        exit = 1'b0;
        total++;
        if (state !== 3'd0 || error !== 1'b0 || led_req !== 1'b0 || valid !== 1'b0 || balance !== 16'd0) begin
            bad++;
            $display("FAIL exit_wins: state=%0d err=%b req=%b valid=%b bal=%0d want 0 0 0 0 0",
                     state, error, led_req, valid, balance);
        end
    endtask

    task automatic test_timeout();
        login(12'h0a1, 4'h3);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        total++;
        if (state !== 3'd2) begin bad++; $display("FAIL timeout_early: state=%0d want 2", state); end
        step();
        total++;
        if (state !== 3'd0 || valid !== 1'b0 || error !== 1'b1) begin
            bad++;
            $display("FAIL timeout: state=%0d valid=%b err=%b want 0 0 1", state, valid, error);
        end
    endtask

    task automatic test_exit_during_debit();
        login(12'h0b2, 4'h4);
        sb_q.push_back({2'b10, 12'h0b2, 4'h0, 16'd50});
        send_cmd(3'b100, 16'd50);
        exit = 1'b1;
        ledger_serve(2, 1'b1, 16'd850);
        total++;
        if (state !== 3'd0 || valid !== 1'b0 || balance !== 16'd0 || error !== 1'b0) begin
            bad++;
            $display("FAIL exit_debit: state=%0d valid=%b bal=%0d err=%b want 0 0 0 0", state, valid, balance, error);
        end
        exit = 1'b0;
        card_in = 1'b0;
        step();
    endtask

    task automatic test_daily_limit();
        login(12'h0c3, 4'h5);
        sb_q.push_back({2'b10, 12'h0c3, 4'h0, 16'd3000});
        send_cmd(3'b100, 16'd3000);
        ledger_serve(0, 1'b1, 16'd6000);
`ifdef ATM_DAILY_LIMIT_EN
        send_cmd(3'b100, 16'd2500);
        total++;
        if (error !== 1'b1 || led_req !== 1'b0 || state !== 3'd2) begin
            bad++;
            $display("FAIL limit_block: err=%b req=%b state=%0d want 1 0 2", error, led_req, state);
        end
`else
        sb_q.push_back({2'b10, 12'h0c3, 4'h0, 16'd2500});
        send_cmd(3'b100, 16'd2500);
        ledger_serve(0, 1'b1, 16'd3500);
        total++;
        if (error !== 1'b0 || balance !== 16'd3500) begin
            bad++;
            $display("FAIL limit_off: err=%b bal=%0d want 0 3500", error, balance);
        end
`endif
    endtask

    task automatic test_reset_mid_txn();
        send_cmd(3'b011, 16'd0);
        total++;
        if (led_req !== 1'b1) begin bad++; $display("FAIL mid_req: led_req=%b want 1", led_req); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (state !== 3'd0 || led_req !== 1'b0 || valid !== 1'b0 || balance !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset: state=%0d req=%b valid=%b bal=%0d want 0 0 0 0", state, led_req, valid, balance);
        end
        card_in = 1'b0;
        step();
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_lockout();
        test_balance();
        test_withdraw();
        test_deposit_delayed();
        test_exit_with_cmd();
        test_timeout();
        test_exit_during_debit();
        test_daily_limit();
        test_reset_mid_txn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
